aes_io_bridge: RTL and testbench

- Streaming front/back end for the AES-128 iterative core and its control FSM.
- Collects key and data words from a narrow valid/ready input stream into 128-bit registers, then launches one core operation with the key-change and cipher/decipher controls.
- Waits for the core to finish, then streams the 128-bit result out as narrow words on a valid/ready output stream.

---
 rtl/aes_io_bridge.sv | 147 ++++++++++++++
 tb/tb_aes_io_bridge.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_io_bridge.sv
// Stream bridge for the iterative AES-128 core: gathers key/data words into 128-bit
// registers, launches one core operation, then streams the 128-bit result back out.
module aes_io_bridge #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_type,
  input  logic          s_decrypt,
  output logic [127:0]  core_key,
  output logic [127:0]  core_block,
  output logic          core_key_change,
  output logic          core_sel_cypher,
  output logic          core_start,
  input  logic          core_done,
  input  logic [127:0]  core_result,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          busy,
  output logic          err
);

  localparam int unsigned NW = 128 / DW;
  localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LastIdx = CW'(NW - 1);

  typedef enum logic [2:0] {StIdle, StCollect, StLaunch, StWaitCore, StDrain} state_e;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic           grp_key_q;
  logic           decrypt_q;
  logic           key_valid_q;
  logic           key_pending_q;
  logic           err_q;
  logic [127:0]   result_q;

  logic           accept;
  logic [CW-1:0]  widx;
  logic           tgt_key;
  logic           last_word;
  logic [127:0]   wr_val;

  // The first word of a group decides its target directly from s_type.
  always_comb begin
    accept    = s_valid && s_ready;
    widx      = (state_q == StIdle) ? '0 : cnt_q;
    tgt_key   = (state_q == StIdle) ? s_type : grp_key_q;
    last_word = (widx == LastIdx);
    wr_val    = tgt_key ? core_key : core_block;
    for (int unsigned k = 0; k < NW; k++) begin
      if (32'(widx) == k) wr_val[127-k*DW -: DW] = s_data;
    end
  end

  always_comb begin
    m_data = '0;
    if (state_q == StDrain) begin
      for (int unsigned k = 0; k < NW; k++) begin
        if (32'(cnt_q) == k) m_data = result_q[127-k*DW -: DW];
      end
    end
  end

  // s_ready is forced low while reset is held so every output reads 0 in reset.
  assign s_ready         = ((state_q == StIdle) || (state_q == StCollect)) && !reset;
  assign busy            = (state_q != StIdle);
  assign m_valid         = (state_q == StDrain);
  assign m_last          = (state_q == StDrain) && (cnt_q == LastIdx);
  assign core_start      = (state_q == StLaunch);
  assign core_key_change = (state_q == StLaunch) && key_pending_q;
  assign core_sel_cypher = ((state_q == StLaunch) || (state_q == StWaitCore)) && !decrypt_q;
  assign err             = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      grp_key_q     <= 1'b0;
      decrypt_q     <= 1'b0;
      key_valid_q   <= 1'b0;
      key_pending_q <= 1'b0;
      err_q         <= 1'b0;
      result_q      <= '0;
      core_key      <= '0;
      core_block    <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        StIdle, StCollect: begin
          if (accept) begin
            if (tgt_key) core_key <= wr_val;
            else         core_block <= wr_val;
            if (state_q == StIdle) begin
              grp_key_q <= s_type;
              decrypt_q <= s_decrypt;
            end
            if (last_word) begin
              cnt_q <= '0;
              if (tgt_key) begin
                key_valid_q   <= 1'b1;
                key_pending_q <= 1'b1;
                state_q       <= StIdle;
              end else if (key_valid_q) begin
                state_q <= StLaunch;
              end else begin
                err_q   <= 1'b1;
                state_q <= StIdle;
              end
            end else begin
              cnt_q   <= widx + 1'b1;
              state_q <= StCollect;
            end
          end
        end
        StLaunch: begin
          key_pending_q <= 1'b0;
          state_q       <= StWaitCore;
        end
        StWaitCore: begin
          if (core_done) begin
            result_q <= core_result;
            cnt_q    <= '0;
            state_q  <= StDrain;
          end
        end
        StDrain: begin
          if (m_ready) begin
            if (cnt_q == LastIdx) begin
              cnt_q   <= '0;
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_io_bridge.sv
// Directed bench for aes_io_bridge (DW=32): key load, encrypt/decrypt launches,
// back-pressured drain, missing-key error and mid-group reset.
module tb_aes_io_bridge;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_type = 1'b0;
  logic          s_decrypt = 1'b0;
  logic [127:0]  core_key;
  logic [127:0]  core_block;
  logic          core_key_change;
  logic          core_sel_cypher;
  logic          core_start;
  logic          core_done = 1'b0;
  logic [127:0]  core_result = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          err;

  aes_io_bridge #(.DW(DW)) dut (
    .clk             (clk),
    .reset           (reset),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .s_type          (s_type),
    .s_decrypt       (s_decrypt),
    .core_key        (core_key),
    .core_block      (core_block),
    .core_key_change (core_key_change),
    .core_sel_cypher (core_sel_cypher),
    .core_start      (core_start),
    .core_done       (core_done),
    .core_result     (core_result),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .m_last          (m_last),
    .busy            (busy),
    .err             (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int starts = 0;
  int hs = 0;

  always @(posedge clk) begin
    if (core_start) starts <= starts + 1;
    if (m_valid && m_ready) hs <= hs + 1;
  end

  localparam logic [127:0] Key  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] Pt   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Ct   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Blk3 = 128'hcafef00d_12345678_9abcdef0_0badc0de;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called at a negedge; returns at the negedge after the word was accepted.
  task automatic send_word(input logic [31:0] d, input logic t, input logic dec);
    int w = 0;
    s_valid = 1'b1; s_data = d; s_type = t; s_decrypt = dec;
    while (!s_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) chk("s_ready_wait", s_ready, 1'b1);
    @(negedge clk);
  endtask

  // Non-first words carry inverted type/decrypt, which the bridge must ignore.
  task automatic send_group(input logic [127:0] v, input logic t, input logic dec);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) send_word(v[127-i*32 -: 32], t, dec);
      else        send_word(v[127-i*32 -: 32], !t, !dec);
    end
    s_valid = 1'b0;
  endtask

  // Entered at the negedge right after the last data word was accepted.
  task automatic run_core(input logic [127:0] res, input logic kc, input logic sc,
                          input logic [127:0] exp_key, input logic [127:0] exp_blk);
    chk("core_start", core_start, 1'b1);
    chk("key_change", core_key_change, kc);
    chk("sel_cypher_launch", core_sel_cypher, sc);
    chk("core_key_launch", core_key, exp_key);
    chk("core_block_launch", core_block, exp_blk);
    s_valid = 1'b1; s_data = 32'hdeadbeef; s_type = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("start_one_cycle", core_start, 1'b0);
      chk("sel_cypher_held", core_sel_cypher, sc);
      chk("s_ready_wait_core", s_ready, 1'b0);
      chk("busy_wait_core", busy, 1'b1);
    end
    core_done = 1'b1; core_result = res; s_valid = 1'b0;
    @(negedge clk);
    core_done = 1'b0; core_result = '0;
    chk("core_key_kept", core_key, exp_key);
    chk("core_block_kept", core_block, exp_blk);
  endtask

  task automatic drain(input logic [127:0] exp, input logic [3:0] pat);
    int i = 0;
    int c = 0;
    int hs0 = hs;
    logic r;
    while (i < 4 && c < 40) begin
      chk("m_valid", m_valid, 1'b1);
      chk("m_data", m_data, exp[127-i*32 -: 32]);
      chk("m_last", m_last, i == 3);
      r = pat[c%4];
      m_ready = r;
      @(negedge clk);
      if (r) i++;
      c++;
    end
    m_ready = 1'b0;
    chk("drain_words", i, 4);
    chk("m_valid_after", m_valid, 1'b0);
    chk("busy_after", busy, 1'b0);
    chk("handshakes", hs - hs0, 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_core_key", core_key, '0);
    chk("rst_core_block", core_block, '0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_start", core_start, 1'b0);
    chk("rst_err", err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", s_ready, 1'b1);

    // Data with no key: dropped with a single err pulse.
    send_group(Pt, 1'b0, 1'b0);
    chk("nokey_err", err, 1'b1);
    chk("nokey_start", core_start, 1'b0);
    chk("nokey_busy", busy, 1'b0);
    chk("nokey_s_ready", s_ready, 1'b1);
    @(negedge clk);
    chk("nokey_err_pulse", err, 1'b0);
    chk("nokey_starts", starts, 0);

    // Key load, then encrypt.
    send_group(Key, 1'b1, 1'b0);
    chk("key_no_start", core_start, 1'b0);
    chk("key_busy", busy, 1'b0);
    chk("key_reg", core_key, Key);
    send_group(Pt, 1'b0, 1'b0);
    run_core(Ct, 1'b1, 1'b1, Key, Pt);
    drain(Ct, 4'b1111);

    // Decrypt with the same key, back-pressured drain.
    send_group(Ct, 1'b0, 1'b1);
    run_core(Pt, 1'b0, 1'b0, Key, Ct);
    drain(Pt, 4'b1001);

    // Spurious core_done in idle.
    core_done = 1'b1; core_result = Blk3;
    @(negedge clk);
    core_done = 1'b0; core_result = '0;
    @(negedge clk);
    chk("spurious_m_valid", m_valid, 1'b0);
    chk("spurious_busy", busy, 1'b0);
    chk("starts_total", starts, 2);

    // Reset after two data words.
    send_word(32'h11111111, 1'b0, 1'b0);
    send_word(32'h22222222, 1'b1, 1'b1);
    s_valid = 1'b0;
    chk("partial_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_s_ready", s_ready, 1'b0);
    chk("midrst_key", core_key, '0);
    chk("midrst_block", core_block, '0);
    chk("midrst_m_valid", m_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_group(Blk3, 1'b0, 1'b0);
    chk("postrst_err", err, 1'b1);
    chk("postrst_start", core_start, 1'b0);
    chk("postrst_block", core_block, Blk3);
    @(negedge clk);
    chk("postrst_starts", starts, 2);
    chk("postrst_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
